axi_wr_fifo_reader: RTL and testbench

AXI_WR_FIFO_READER -- requirements
Module: axi_wr_fifo_reader

---
 rtl/axi_slave_package.sv | 18 +
 rtl/axi_wr_fifo_reader_if.sv | 51 +++++
 rtl/axi_wr_fifo_reader.sv | 138 +++++++++++++
 tb/tb_axi_wr_fifo_reader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_package.sv
// Shared types and constants for the AXI write FIFO reader.
// Contents:
//   state_t     - reader FSM states
//   TRUE/FALSE  - single-bit logic constants
package axi_slave_package;

  typedef enum logic [2:0] {
    IDLE,
    AW_RD,
    HDR,
    W_RD,
    BEAT
  } state_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/axi_wr_fifo_reader_if.sv
// Bundle of FIFO-side and downstream-side signals of the AXI write FIFO reader.
// Ports (slave = reader side):
//   aw_fifo_empty/aw_fifo_rd_en/aw_fifo_rd_data  AW FIFO read port, entry {id, addr, len}
//   w_fifo_empty/w_fifo_rd_en/w_fifo_rd_data     W FIFO read port, entry {data, strb, last}
//   req_valid/req_ready/req_id/req_addr/req_len  downstream header handshake
//   beat_valid/beat_ready/beat_data/beat_strb/beat_last  downstream data handshake
interface axi_wr_fifo_reader_if #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4,
  parameter int DATA_W = 128
);
  localparam int STRB_W = DATA_W / 8;

  logic                           aw_fifo_empty;
  logic                           aw_fifo_rd_en;
  logic [ID_W+ADDR_W+LEN_W-1:0]   aw_fifo_rd_data;

  logic                           w_fifo_empty;
  logic                           w_fifo_rd_en;
  logic [DATA_W+STRB_W:0]         w_fifo_rd_data;

  logic                           req_valid;
  logic                           req_ready;
  logic [ID_W-1:0]                req_id;
  logic [ADDR_W-1:0]              req_addr;
  logic [LEN_W-1:0]               req_len;

  logic                           beat_valid;
  logic                           beat_ready;
  logic [DATA_W-1:0]              beat_data;
  logic [STRB_W-1:0]              beat_strb;
  logic                           beat_last;

  modport slave (
    input  aw_fifo_empty, aw_fifo_rd_data, w_fifo_empty, w_fifo_rd_data,
    input  req_ready, beat_ready,
    output aw_fifo_rd_en, w_fifo_rd_en,
    output req_valid, req_id, req_addr, req_len,
    output beat_valid, beat_data, beat_strb, beat_last
  );

  modport master (
    output aw_fifo_empty, aw_fifo_rd_data, w_fifo_empty, w_fifo_rd_data,
    output req_ready, beat_ready,
    input  aw_fifo_rd_en, w_fifo_rd_en,
    input  req_valid, req_id, req_addr, req_len,
    input  beat_valid, beat_data, beat_strb, beat_last
  );

endinterface

// File: rtl/axi_wr_fifo_reader.sv
// Drains an AW FIFO and a W FIFO and replays each write burst downstream as
// one header followed by len+1 data beats. The beat counter loaded from AWLEN
// decides beat_last; the W FIFO last bit is only checked (err_len).
// Ports:
//   clk      single clock, posedge
//   arst     asynchronous active-low reset
//   bus      FIFO read ports and downstream handshakes (slave modport)
//   err_len  one-cycle pulse when an accepted beat's FIFO last bit disagrees with the counter
//   busy     high whenever the FSM is not IDLE
module axi_wr_fifo_reader
  import axi_slave_package::*;
#(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4,
  parameter int DATA_W = 128
) (
  input  logic                 clk,
  input  logic                 arst,
  axi_wr_fifo_reader_if.slave  bus,
  output logic                 err_len,
  output logic                 busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int AW_W   = ID_W + ADDR_W + LEN_W;

  state_t             state;
  state_t             next_state;
  logic               aw_pop;
  logic               w_pop;
  logic               w_pend;
  logic               cnt_zero;

  logic [ID_W-1:0]    id_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  data_q;
  logic [STRB_W-1:0]  strb_q;
  logic               last_q;

  assign cnt_zero = (cnt_q == '0);

  // State register.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and FIFO pops. W_RD is split by w_pend: the first cycle pops,
  // the second cycle sees the popped entry and moves on, so a pop is never
  // outstanding while another is issued.
  always_comb begin
    next_state = state;
    aw_pop     = FALSE;
    w_pop      = FALSE;
    case (state)
      IDLE: begin
        if (!bus.aw_fifo_empty) begin
          aw_pop     = TRUE;
          next_state = AW_RD;
        end
      end
      AW_RD: next_state = HDR;
      HDR: begin
        if (bus.req_ready) next_state = W_RD;
      end
      W_RD: begin
        if (w_pend) begin
          next_state = BEAT;
        end else if (!bus.w_fifo_empty) begin
          w_pop = TRUE;
        end
      end
      BEAT: begin
        if (bus.beat_ready) next_state = cnt_zero ? IDLE : W_RD;
      end
      default: next_state = IDLE;
    endcase
  end

  // Header/beat capture and beat counter. Everything clears on reset so all
  // downstream payload outputs read zero while arst is low.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      strb_q <= '0;
      last_q <= FALSE;
      w_pend <= FALSE;
    end else begin
      if (state == AW_RD) begin
        id_q   <= bus.aw_fifo_rd_data[AW_W-1 -: ID_W];
        addr_q <= bus.aw_fifo_rd_data[ADDR_W+LEN_W-1 -: ADDR_W];
        len_q  <= bus.aw_fifo_rd_data[LEN_W-1:0];
        cnt_q  <= bus.aw_fifo_rd_data[LEN_W-1:0];
      end
      if (w_pop) begin
        w_pend <= TRUE;
      end
      if (state == W_RD && w_pend) begin
        data_q <= bus.w_fifo_rd_data[DATA_W+STRB_W -: DATA_W];
        strb_q <= bus.w_fifo_rd_data[STRB_W:1];
        last_q <= bus.w_fifo_rd_data[0];
        w_pend <= FALSE;
      end
      if (state == BEAT && bus.beat_ready && !cnt_zero) begin
        cnt_q <= cnt_q - LEN_W'(1);
      end
    end
  end

  // The AW pop is combinational on the empty flag; gating it with arst keeps
  // it low during reset even though the reset state is IDLE.
  assign bus.aw_fifo_rd_en = aw_pop & arst;
  assign bus.w_fifo_rd_en  = w_pop;

  assign bus.req_valid  = (state == HDR);
  assign bus.req_id     = id_q;
  assign bus.req_addr   = addr_q;
  assign bus.req_len    = len_q;

  assign bus.beat_valid = (state == BEAT);
  assign bus.beat_data  = data_q;
  assign bus.beat_strb  = strb_q;
  assign bus.beat_last  = (state == BEAT) && cnt_zero;

  assign err_len = (state == BEAT) && bus.beat_ready && (last_q != cnt_zero);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_axi_wr_fifo_reader.sv
// Self-checking bench for axi_wr_fifo_reader. Models both FIFOs with queues
// (read data appears one cycle after the pop), drives downstream ready with
// per-burst stall patterns, and scoreboards headers and beats.
module tb_axi_wr_fifo_reader;

  localparam int ADDR_W = 64;
  localparam int LEN_W  = 8;
  localparam int ID_W   = 4;
  localparam int DATA_W = 128;
  localparam int STRB_W = DATA_W / 8;
  localparam int AW_W   = ID_W + ADDR_W + LEN_W;
  localparam int BW     = DATA_W + STRB_W + 1;

  typedef logic [191:0] cval_t;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    int                len;
    logic [15:0]       stall_mask;
    int                hdr_stall;
    int                bad_idx;
    int                exp_beats;
    int                exp_errs;
  } vec_t;

  logic clk = 1'b0;
  logic arst;
  logic err_len;
  logic busy;

  axi_wr_fifo_reader_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

  axi_wr_fifo_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .arst    (arst),
    .bus     (bus),
    .err_len (err_len),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [AW_W-1:0] aw_q[$];
  logic [BW-1:0]   w_q[$];
  logic [AW_W-1:0] exp_hdr[$];
  logic [AW_W-1:0] got_hdr[$];
  logic [BW-1:0]   exp_beat[$];
  logic [BW-1:0]   got_beat[$];

  int          aw_pops, w_pops, err_cnt, err_at;
  int          hdr_wait, beat_wait, cur_hdr_stall;
  logic [15:0] cur_mask;
  bit          w_hold;
  bit          hdr_stalled, beat_stalled;
  logic [AW_W-1:0] hdr_prev;
  logic [BW-1:0]   beat_prev;

  vec_t vecs[5];

  // Every comparison goes through here so the counters stay honest.
  task automatic checkOutput(input string name, input cval_t actual, input cval_t expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] mkData(input int vi, input int b);
    return {32'hDA7A_0000 | 32'(vi), 32'(b), ~32'(b), 32'(vi * 1000 + b)};
  endfunction

  function automatic logic [STRB_W-1:0] mkStrb(input int vi, input int b);
    return 16'hF0F0 ^ 16'(b * 3 + vi);
  endfunction

  task automatic updateEmpty();
    bus.aw_fifo_empty = (aw_q.size() == 0);
    bus.w_fifo_empty  = (w_q.size() == 0) || w_hold;
  endtask

  task automatic pushAw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len);
    aw_q.push_back({id, addr, LEN_W'(len)});
    exp_hdr.push_back({id, addr, LEN_W'(len)});
    updateEmpty();
  endtask

  task automatic pushW(input int vi, input int b, input logic fifo_last, input logic exp_last);
    w_q.push_back({mkData(vi, b), mkStrb(vi, b), fifo_last});
    exp_beat.push_back({mkData(vi, b), mkStrb(vi, b), exp_last});
    updateEmpty();
  endtask

  task automatic clearScoreboard();
    exp_hdr.delete(); got_hdr.delete(); exp_beat.delete(); got_beat.delete();
    aw_pops = 0; w_pops = 0; err_cnt = 0; err_at = -1;
    hdr_wait = 0; beat_wait = 0; cur_hdr_stall = 0; cur_mask = '0;
    hdr_stalled = 0; beat_stalled = 0;
  endtask

  // One clock: monitor at the falling edge, then model the FIFOs and drive
  // ready just after the rising edge.
  task automatic step();
    logic aw_pop_s, w_pop_s;
    logic [AW_W-1:0] cur_hdr;
    logic [BW-1:0]   cur_beat;
    int idx;
    @(negedge clk);
    checkOutput("aw_pop_while_empty", cval_t'(bus.aw_fifo_rd_en & bus.aw_fifo_empty), '0);
    checkOutput("w_pop_while_empty", cval_t'(bus.w_fifo_rd_en & bus.w_fifo_empty), '0);
    aw_pop_s = bus.aw_fifo_rd_en;
    w_pop_s  = bus.w_fifo_rd_en;
    if (aw_pop_s) aw_pops++;
    if (w_pop_s) w_pops++;
    if (err_len) err_cnt++;
    if (bus.req_valid) begin
      cur_hdr = {bus.req_id, bus.req_addr, bus.req_len};
      if (hdr_stalled) checkOutput("req_stable_in_stall", cval_t'(cur_hdr), cval_t'(hdr_prev));
      if (bus.req_ready) begin
        got_hdr.push_back(cur_hdr);
        hdr_wait = 0;
      end
      hdr_stalled = !bus.req_ready;
      hdr_prev    = cur_hdr;
    end else begin
      hdr_stalled = 0;
    end
    if (bus.beat_valid) begin
      cur_beat = {bus.beat_data, bus.beat_strb, bus.beat_last};
      if (beat_stalled) checkOutput("beat_stable_in_stall", cval_t'(cur_beat), cval_t'(beat_prev));
      if (bus.beat_ready) begin
        if (err_len && err_at < 0) err_at = got_beat.size();
        got_beat.push_back(cur_beat);
        beat_wait = 0;
      end
      beat_stalled = !bus.beat_ready;
      beat_prev    = cur_beat;
    end else begin
      beat_stalled = 0;
    end
    @(posedge clk);
    #1;
    if (aw_pop_s && aw_q.size() > 0) bus.aw_fifo_rd_data = aw_q.pop_front();
    if (w_pop_s && w_q.size() > 0) bus.w_fifo_rd_data = w_q.pop_front();
    updateEmpty();
    if (bus.req_valid && hdr_wait < cur_hdr_stall) begin
      bus.req_ready = 1'b0;
      hdr_wait++;
    end else begin
      bus.req_ready = bus.req_valid;
    end
    idx = got_beat.size();
    if (bus.beat_valid && idx < 16 && cur_mask[4'(idx)] && beat_wait < 2) begin
      bus.beat_ready = 1'b0;
      beat_wait++;
    end else begin
      bus.beat_ready = bus.beat_valid;
    end
  endtask

  task automatic runUntilIdle(input string name, input int budget);
    bit done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      done = (got_beat.size() >= exp_beat.size()) && (got_hdr.size() >= exp_hdr.size())
             && !busy && (aw_q.size() == 0);
    end
    if (!done) checkOutput({name, "_timeout"}, '0, cval_t'(1));
  endtask

  task automatic checkScoreboard(input string name);
    checkOutput({name, "_hdr_count"}, cval_t'(got_hdr.size()), cval_t'(exp_hdr.size()));
    for (int i = 0; i < got_hdr.size() && i < exp_hdr.size(); i++)
      checkOutput($sformatf("%s_hdr%0d", name, i), cval_t'(got_hdr[i]), cval_t'(exp_hdr[i]));
    checkOutput({name, "_beat_count"}, cval_t'(got_beat.size()), cval_t'(exp_beat.size()));
    for (int i = 0; i < got_beat.size() && i < exp_beat.size(); i++)
      checkOutput($sformatf("%s_beat%0d", name, i), cval_t'(got_beat[i]), cval_t'(exp_beat[i]));
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_aw_rd_en"},  cval_t'(bus.aw_fifo_rd_en), '0);
    checkOutput({name, "_w_rd_en"},   cval_t'(bus.w_fifo_rd_en), '0);
    checkOutput({name, "_req_valid"}, cval_t'(bus.req_valid), '0);
    checkOutput({name, "_req_id"},    cval_t'(bus.req_id), '0);
    checkOutput({name, "_req_addr"},  cval_t'(bus.req_addr), '0);
    checkOutput({name, "_req_len"},   cval_t'(bus.req_len), '0);
    checkOutput({name, "_beat_valid"}, cval_t'(bus.beat_valid), '0);
    checkOutput({name, "_beat_data"}, cval_t'(bus.beat_data), '0);
    checkOutput({name, "_beat_strb"}, cval_t'(bus.beat_strb), '0);
    checkOutput({name, "_beat_last"}, cval_t'(bus.beat_last), '0);
    checkOutput({name, "_err_len"},   cval_t'(err_len), '0);
    checkOutput({name, "_busy"},      cval_t'(busy), '0);
  endtask

  // One table burst: preload AW and all W beats, run, compare everything.
  task automatic applyStimulus(input vec_t v, input int vi);
    string name;
    name = $sformatf("vec%0d", vi);
    clearScoreboard();
    cur_mask      = v.stall_mask;
    cur_hdr_stall = v.hdr_stall;
    pushAw(v.id, v.addr, v.len);
    for (int b = 0; b <= v.len; b++)
      pushW(vi, b, (b == v.len) ^ (b == v.bad_idx), b == v.len);
    runUntilIdle(name, 4000);
    checkScoreboard(name);
    checkOutput({name, "_beats"},   cval_t'(got_beat.size()), cval_t'(v.exp_beats));
    checkOutput({name, "_w_pops"},  cval_t'(w_pops), cval_t'(v.exp_beats));
    checkOutput({name, "_err_cnt"}, cval_t'(err_cnt), cval_t'(v.exp_errs));
    checkOutput({name, "_err_beat"}, cval_t'(err_at), cval_t'(v.bad_idx));
    checkOutput({name, "_idle"},    cval_t'(busy), '0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    //             id     addr                     len  stall   hstall bad  beats errs
    vecs[0] = '{4'd3,  64'h1000,                   0,  16'h0,  0,    -1,   1,    0};
    vecs[1] = '{4'd5,  64'h2000,                   3,  16'hA,  2,    -1,   4,    0};
    vecs[2] = '{4'd1,  64'h2040,                   1,  16'h0,  0,     0,   2,    1};
    vecs[3] = '{4'd15, 64'hFFFF_FFFF_FFFF_FFF0,  255,  16'h0,  0,    -1, 256,    0};
    vecs[4] = '{4'd9,  64'h0000_0001_0000_0000,    2,  16'h4,  1,     2,   3,    1};

    arst = 1'b0;
    w_hold = 0;
    bus.aw_fifo_empty   = 1'b0;
    bus.w_fifo_empty    = 1'b1;
    bus.aw_fifo_rd_data = '0;
    bus.w_fifo_rd_data  = '0;
    bus.req_ready       = 1'b0;
    bus.beat_ready      = 1'b0;
    clearScoreboard();
    #12;
    checkAllZero("reset");
    updateEmpty();
    @(posedge clk);
    #1;
    arst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checkOutput("post_reset_no_pop", cval_t'(aw_pops), '0);
    checkOutput("post_reset_idle", cval_t'(busy), '0);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // W FIFO starved after the header: no pop may happen until data shows up.
    clearScoreboard();
    w_hold = 1;
    pushAw(4'd2, 64'h5000, 1);
    pushW(10, 0, 1'b0, 1'b0);
    pushW(10, 1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step();
    checkOutput("w_starved_no_pop", cval_t'(w_pops), '0);
    checkOutput("w_starved_busy", cval_t'(busy), cval_t'(1));
    checkOutput("w_starved_no_beat", cval_t'(got_beat.size()), '0);
    w_hold = 0;
    updateEmpty();
    runUntilIdle("w_starved", 200);
    checkScoreboard("w_starved");

    // Reset in the middle of a long burst.
    clearScoreboard();
    pushAw(4'd4, 64'h6000, 7);
    for (int b = 0; b <= 7; b++) pushW(11, b, b == 7, b == 7);
    for (int c = 0; c < 100 && !(got_beat.size() >= 2 && bus.beat_valid); c++) step();
    checkOutput("midreset_in_beat", cval_t'(bus.beat_valid), cval_t'(1));
    #3;
    arst = 1'b0;
    #1;
    checkAllZero("midreset");
    bus.aw_fifo_empty = 1'b0;
    #1;
    checkOutput("midreset_aw_rd_en_gated", cval_t'(bus.aw_fifo_rd_en), '0);
    aw_q.delete();
    w_q.delete();
    updateEmpty();
    @(posedge clk);
    #1;
    checkOutput("midreset_held_busy", cval_t'(busy), '0);
    arst = 1'b1;
    bus.req_ready  = 1'b0;
    bus.beat_ready = 1'b0;
    clearScoreboard();
    for (int i = 0; i < 3; i++) step();
    checkOutput("midreset_released_idle", cval_t'(busy), '0);
    checkOutput("midreset_released_no_pop", cval_t'(aw_pops + w_pops), '0);

    // Two bursts queued back to back.
    clearScoreboard();
    pushAw(4'd6, 64'h3000, 0);
    pushAw(4'd7, 64'h4000, 2);
    pushW(12, 0, 1'b1, 1'b1);
    base = 1;
    for (int b = 0; b <= 2; b++) pushW(12, base + b, b == 2, b == 2);
    runUntilIdle("b2b", 400);
    checkScoreboard("b2b");
    checkOutput("b2b_err_cnt", cval_t'(err_cnt), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
